// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and request classification for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        REQ_OK,
        REQ_ILLEGAL,
        REQ_MISALIGNED
    } req_class_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Size is encoded in funct3[1:0] for every legal load and store.
    function automatic req_class_e classify_req(input logic       we,
                                                input logic [2:0] funct3,
                                                input logic [1:0] addr_lo);
        logic legal;
        if (we)
            legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        else
            legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU);
        if (!legal)
            return REQ_ILLEGAL;
        if ((funct3[1:0] == 2'b01 && addr_lo[0]) ||
            (funct3[1:0] == 2'b10 && addr_lo != 2'b00))
            return REQ_MISALIGNED;
        return REQ_OK;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: load extraction/extension and store lane merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [31:0] shifted;

    always_comb begin
        shifted = mem_word >> {addr_lo, 3'b000};
        load_data = mem_word;
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {24'h0, shifted[7:0]};
            F3_LHU:  load_data = {16'h0, shifted[15:0]};
            default: load_data = mem_word;
        endcase
    end

    always_comb begin
        merged_word = mem_word;
        case (funct3[1:0])
            2'b00:   merged_word[{addr_lo, 3'b000} +: 8]     = store_data[7:0];
            2'b01:   merged_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/lsu_datapath.sv
// Load/store unit: request FSM, RAM sequencing (incl. sub-word read-modify-write) and response hold.
module lsu_datapath
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [31:0]              req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    lsu_state_e               state_q, state_d;
    logic                     we_q;
    logic [2:0]               funct3_q;
    logic [ADDRESS_WIDTH+1:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     err_q;
    logic                     accept;
    req_class_e               req_class;
    logic [DATA_WIDTH-1:0]    load_data;
    logic [DATA_WIDTH-1:0]    merged_word;
    logic                     unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDRESS_WIDTH+2];

    assign accept    = req_valid && req_ready;
    assign req_class = classify_req(req_we, req_funct3, req_addr[1:0]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_class != REQ_OK)
                        state_d = RESP;
                    else if (req_we && req_funct3 == F3_SW)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ:    state_d = WAIT;
            WAIT:    state_d = we_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr[ADDRESS_WIDTH+1:0];
                data_q   <= (req_class == REQ_OK && req_we) ? req_wdata : '0;
                rdata_q  <= '0;
                err_q    <= (req_class != REQ_OK);
            end
            // mem_rdata for the READ address is valid during WAIT
            if (state_q == WAIT) begin
                if (we_q)
                    data_q <= merged_word;
                else
                    rdata_q <= load_data;
            end
        end
    end

    lsu_align u_align (
        .funct3      (funct3_q),
        .addr_lo     (addr_q[1:0]),
        .mem_word    (mem_rdata),
        .store_data  (data_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    // Gated by rst so a store caught in WRITE by reset never reaches the RAM.
    assign mem_we     = (state_q == WRITE) && !rst;
    assign mem_addr   = addr_q[ADDRESS_WIDTH+1:2];
    assign mem_wdata  = (state_q == WRITE) ? data_q : '0;

endmodule

// File: tb/tb_lsu_datapath.sv
// Table-driven bench for lsu_datapath with a behavioural synchronous RAM and a response scoreboard.
module tb_lsu_datapath;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0] ram [0:(1<<AW)-1];
    int          we_pulses = 0;
    int          total = 0;
    int          passed = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        int          hold;
    } vec_t;
    vec_t vecs[19];

    always #5 clk = ~clk;

    lsu_datapath #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_pulses     <= we_pulses + 1;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic do_req(input vec_t v);
        int          n;
        int          pulses0;
        logic [31:0] cap;
        logic [AW-1:0] exp_wa;
        exp_t        e;
        exp_wa = v.addr[AW+1:2];
        check("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        sb_q.push_back('{rdata: v.exp_rd, err: v.exp_err});
        pulses0 = we_pulses;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        if (v.lat > 1) check("mem_addr_latched", {22'h0, mem_addr}, {22'h0, exp_wa});
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, v.lat);
        check("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
        cap = resp_rdata;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check("hold_stable", {resp_valid, req_ready, resp_rdata == cap}, {1'b1, 1'b0, 1'b1});
        end
        resp_ready = 1'b1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        end else begin
            check("scoreboard_nonempty", 32'h0, 32'h1);
        end
        @(negedge clk);
        resp_ready = 1'b0;
        check("back_to_idle", {resp_valid, req_ready}, {1'b0, 1'b1});
        check("we_pulses", we_pulses - pulses0, (v.we && !v.exp_err) ? 1 : 0);
    endtask

    initial begin
        int pulses0;
        vecs[0]  = '{1'b1, 3'b010, 32'h0000_0014, 32'h8899_AABB, 32'h0,          1'b0, 2, 0};
        vecs[1]  = '{1'b1, 3'b010, 32'h0000_0010, 32'h7F00_0000, 32'h0,          1'b0, 2, 0};
        vecs[2]  = '{1'b0, 3'b000, 32'h0000_0015, 32'h0,         32'hFFFF_FFAA,  1'b0, 3, 0};
        vecs[3]  = '{1'b0, 3'b100, 32'h0000_0015, 32'h0,         32'h0000_00AA,  1'b0, 3, 0};
        vecs[4]  = '{1'b0, 3'b001, 32'h0000_0016, 32'h0,         32'hFFFF_8899,  1'b0, 3, 0};
        vecs[5]  = '{1'b0, 3'b101, 32'h0000_0014, 32'h0,         32'h0000_AABB,  1'b0, 3, 5};
        vecs[6]  = '{1'b0, 3'b010, 32'h0000_0014, 32'h0,         32'h8899_AABB,  1'b0, 3, 0};
        vecs[7]  = '{1'b0, 3'b000, 32'h0000_0013, 32'h0,         32'h0000_007F,  1'b0, 3, 0};
        vecs[8]  = '{1'b1, 3'b001, 32'h0000_0016, 32'hCAFE_1234, 32'h0,          1'b0, 4, 0};
        vecs[9]  = '{1'b0, 3'b010, 32'h0000_0014, 32'h0,         32'h1234_AABB,  1'b0, 3, 0};
        vecs[10] = '{1'b1, 3'b000, 32'h0000_0017, 32'hFFFF_FF56, 32'h0,          1'b0, 4, 0};
        vecs[11] = '{1'b0, 3'b010, 32'h0000_0014, 32'h0,         32'h5634_AABB,  1'b0, 3, 0};
        vecs[12] = '{1'b0, 3'b010, 32'h0000_0002, 32'h0,         32'h0,          1'b1, 1, 0};
        vecs[13] = '{1'b1, 3'b001, 32'h0000_0003, 32'h1111_2222, 32'h0,          1'b1, 1, 0};
        vecs[14] = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,          1'b1, 1, 0};
        vecs[15] = '{1'b1, 3'b100, 32'h0000_0000, 32'h3333_4444, 32'h0,          1'b1, 1, 0};
        vecs[16] = '{1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,          1'b0, 2, 0};
        vecs[17] = '{1'b0, 3'b010, 32'h0000_0000, 32'h0,         32'hDEAD_BEEF,  1'b0, 3, 0};
        vecs[18] = '{1'b0, 3'b001, 32'h0000_0013, 32'h0,         32'h0,          1'b1, 1, 0};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'h0, req_ready}, 32'h0);
        check("reset_outputs", {resp_valid, resp_err, mem_we}, 3'b000);
        check("reset_rdata", resp_rdata, 32'h0);
        check("reset_mem_addr", {22'h0, mem_addr}, 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 19; i++) do_req(vecs[i]);

        check("ram_word5", ram[5], 32'h5634_AABB);
        check("ram_word0_wrap", ram[0], 32'hDEAD_BEEF);

        // SB interrupted by reset while in WRITE
        pulses0    = we_pulses;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0000_0014;
        req_wdata  = 32'h0000_0077;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rmw_reaches_write", {31'h0, mem_we}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_forces_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_ready_low", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check("rst_no_resp", {31'h0, resp_valid}, 32'h0);
        rst = 1'b0;
        #1;
        check("ready_after_abort", {31'h0, req_ready}, 32'h1);
        repeat (3) begin
            @(negedge clk);
            check("no_resp_after_abort", {resp_valid, req_ready}, {1'b0, 1'b1});
        end
        check("ram_unchanged_after_abort", ram[5], 32'h5634_AABB);
        check("no_write_after_abort", we_pulses - pulses0, 0);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1);
    end

endmodule
